// File: rtl/wave_gen_pkg.sv
// Shared definitions for the multi-mode waveform generator.
// Mode encodings match the 2-bit mode input of wave_gen.
package wave_gen_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SAW   = 2'd0,
    MODE_SQR   = 2'd1,
    MODE_TRI   = 2'd2,
    MODE_RECIP = 2'd3
  } wave_mode_e;

  // Triangle fold: doubled phase, mirrored in the upper half of the period.
  function automatic logic [7:0] tri_fold8(input logic [7:0] p);
    logic [7:0] s;
    s = {p[6:0], 1'b0};
    return p[7] ? ~s : s;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per clock, WIDTH clocks from start to done.
// The first iteration is folded into the start cycle so done pulses exactly WIDTH cycles after start.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    DV_IDLE,
    DV_RUN
  } dv_state_e;

  dv_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] den_q;

  logic [WIDTH-1:0] src_rem;
  logic [WIDTH-1:0] src_quo;
  logic [WIDTH-1:0] src_den;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] nxt_rem;
  logic [WIDTH-1:0] nxt_quo;

  assign busy = (state_q == DV_RUN);

  always_comb begin
    src_rem = '0;
    src_quo = dividend;
    src_den = divisor;
    if (state_q == DV_RUN) begin
      src_rem = rem_q;
      src_quo = quo_q;
      src_den = den_q;
    end
    // Shift the next dividend bit into the partial remainder and try a subtract.
    trial = {src_rem, src_quo[WIDTH-1]};
    diff  = trial - {1'b0, src_den};
    if (!diff[WIDTH]) begin
      nxt_rem = diff[WIDTH-1:0];
      nxt_quo = {src_quo[WIDTH-2:0], 1'b1};
    end else begin
      nxt_rem = trial[WIDTH-1:0];
      nxt_quo = {src_quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      den_q    <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        DV_IDLE: begin
          if (start) begin
            rem_q   <= nxt_rem;
            quo_q   <= nxt_quo;
            den_q   <= divisor;
            cnt_q   <= CNT_W'(WIDTH - 1);
            state_q <= DV_RUN;
          end
        end
        DV_RUN: begin
          rem_q <= nxt_rem;
          quo_q <= nxt_quo;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            quotient <= nxt_quo;
            done     <= 1'b1;
            state_q  <= DV_IDLE;
          end
        end
        default: state_q <= DV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wave_gen.sv
// Multi-mode waveform generator: prescaled phase counter feeding a sample mux.
// Reciprocal samples are produced by seq_divider and stall the prescaler while in flight.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [DIV_W-1:0]  freq_div,
  output logic [WIDTH-1:0]  wave,
  output logic              wave_valid,
  output logic              period_start
);

  localparam logic [WIDTH-1:0] FULL_SCALE = '1;

  logic [DIV_W-1:0] pre_cnt;
  logic [WIDTH-1:0] phase;
  wave_mode_e       mode_q;

  wave_mode_e       mode_in;
  wave_mode_e       sel_mode;
  logic [WIDTH-1:0] p_next;
  logic             p_wrap;
  logic             tick;
  logic             recip_path;
  logic [WIDTH-1:0] tri_s;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] div_den;

  logic             div_start;
  logic             dv_busy;
  logic             dv_done;
  logic             div_busy;
  logic [WIDTH-1:0] dv_quotient;

  always_comb begin
    mode_in  = wave_mode_e'(mode);
    p_next   = phase + WIDTH'(1);
    p_wrap   = (p_next == '0);
    // A new mode takes effect on the wrapping sample, so phase 0 already uses it.
    sel_mode = p_wrap ? mode_in : mode_q;
    div_busy = div_start | dv_busy | dv_done;
    tick     = en & (pre_cnt >= freq_div) & ~div_busy;
    recip_path = (sel_mode == MODE_RECIP) && !p_wrap;
    tri_s    = {p_next[WIDTH-2:0], 1'b0};
    // Phase is frozen while the divider runs, so its negation is the divisor 2^WIDTH - p.
    div_den  = ~phase + WIDTH'(1);
    sample   = '0;
    case (sel_mode)
      MODE_SAW: sample = p_next;
      MODE_SQR: sample = p_next[WIDTH-1] ? FULL_SCALE : '0;
      MODE_TRI: sample = p_next[WIDTH-1] ? ~tri_s : tri_s;
      default:  sample = '0;
    endcase
  end

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (FULL_SCALE),
    .divisor  (div_den),
    .busy     (dv_busy),
    .done     (dv_done),
    .quotient (dv_quotient)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt      <= '0;
      phase        <= '0;
      mode_q       <= MODE_SAW;
      wave         <= '0;
      wave_valid   <= 1'b0;
      period_start <= 1'b0;
      div_start    <= 1'b0;
    end else begin
      wave_valid   <= 1'b0;
      period_start <= 1'b0;
      div_start    <= 1'b0;

      if (tick) begin
        pre_cnt <= '0;
      end else if (en) begin
        pre_cnt <= pre_cnt + DIV_W'(1);
      end

      if (!en || (tick && p_wrap)) begin
        mode_q <= mode_in;
      end

      if (tick) begin
        phase <= p_next;
        if (recip_path) begin
          div_start <= 1'b1;
        end else begin
          wave         <= sample;
          wave_valid   <= 1'b1;
          period_start <= p_wrap;
        end
      end

      if (dv_done) begin
        wave       <= dv_quotient;
        wave_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: per-scenario tasks checked against an arithmetic sample/timing model.
module tb_wave_gen;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] freq_div = 8'd0;
  logic [7:0] wave;
  logic       wave_valid;
  logic       period_start;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int base = 0;

  wave_gen #(.WIDTH(W), .DIV_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .freq_div     (freq_div),
    .wave         (wave),
    .wave_valid   (wave_valid),
    .period_start (period_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2ms", $time);
    $fatal(1);
  end

  // Expected sample for phase p, straight from the waveform definitions.
  function automatic int exp_sample(input int m, input int p);
    case (m)
      0: return p;
      1: return (p >= 128) ? 255 : 0;
      2: return (p < 128) ? 2 * p : 511 - 2 * p;
      default: return (p == 0) ? 0 : 255 / (256 - p);
    endcase
  endfunction

  // Clocks from tick to visible sample.
  function automatic int exp_lat(input int m, input int p);
    return (m == 3 && p != 0) ? W + 2 : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output bit to);
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (wave_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // Reset, spend one en=0 cycle so the mode is loaded, then run.
  task automatic restart(input int m, input int fd);
    rst = 1'b1;
    en = 1'b0;
    mode = 2'(m);
    freq_div = 8'(fd);
    step();
    step();
    rst = 1'b0;
    step();
    en = 1'b1;
    base = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'($urandom_range(1));
    mode = 2'($urandom_range(3));
    freq_div = 8'($urandom_range(255));
    repeat (3) step();
    n_checks++;
    if (wave !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_wave: got %0d, expected 0", wave);
    end
    n_checks++;
    if (wave_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b, expected 0", wave_valid);
    end
    n_checks++;
    if (period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_period_start: got %b, expected 0", period_start);
    end
  endtask

  typedef struct {
    int m;
    int fd;
    int n;
  } run_t;

  task automatic test_waveforms();
    run_t runs[$];
    runs.push_back('{0, 0, 300});
    runs.push_back('{2, 3, 260});
    runs.push_back('{1, int'($urandom_range(5)), 260});
    runs.push_back('{3, 0, 260});
    runs.push_back('{3, int'($urandom_range(15)), 40});
    runs.push_back('{2, int'($urandom_range(7)), 30});
    foreach (runs[r]) begin
      int p, t, pn, lat, idx, e;
      bit to;
      p = 0;
      t = runs[r].fd;
      restart(runs[r].m, runs[r].fd);
      for (int k = 0; k < runs[r].n; k++) begin
        pn = (p + 1) % 256;
        lat = exp_lat(runs[r].m, pn);
        e = exp_sample(runs[r].m, pn);
        wait_valid(40, to);
        idx = cyc - base;
        n_checks++;
        if (to) begin
          n_fail++;
          $display("FAIL wf_timeout mode=%0d fd=%0d phase=%0d: got no valid, expected one", runs[r].m, runs[r].fd, pn);
          break;
        end
        n_checks++;
        if (idx !== t + lat) begin
          n_fail++;
          $display("FAIL wf_timing mode=%0d fd=%0d phase=%0d: got cycle %0d, expected %0d", runs[r].m, runs[r].fd, pn, idx, t + lat);
        end
        n_checks++;
        if (wave !== 8'(e)) begin
          n_fail++;
          $display("FAIL wf_value mode=%0d phase=%0d: got %0d, expected %0d", runs[r].m, pn, wave, e);
        end
        n_checks++;
        if (period_start !== (pn == 0)) begin
          n_fail++;
          $display("FAIL wf_period_start mode=%0d phase=%0d: got %b, expected %b", runs[r].m, pn, period_start, pn == 0);
        end
        t = t + max2(runs[r].fd + 1, lat);
        p = pn;
      end
    end
  endtask

  task automatic test_mode_defer();
    int p, pn, cur, pend, em, idx, e;
    bit to;
    p = 0;
    cur = 0;
    pend = 0;
    restart(0, 0);
    for (int k = 0; k < 300; k++) begin
      pn = (p + 1) % 256;
      if (pn == 0) cur = pend;
      em = cur;
      e = exp_sample(em, pn);
      wait_valid(10, to);
      idx = cyc - base;
      n_checks++;
      if (to || idx !== k + 1) begin
        n_fail++;
        $display("FAIL defer_timing phase=%0d: got cycle %0d (timeout %b), expected %0d", pn, idx, to, k + 1);
        break;
      end
      n_checks++;
      if (wave !== 8'(e)) begin
        n_fail++;
        $display("FAIL defer_value phase=%0d: got %0d, expected %0d", pn, wave, e);
      end
      if (pn == 40) begin
        mode = 2'd2;
        pend = 2;
      end
      p = pn;
    end
  endtask

  task automatic test_rst_mid_div();
    int idx, nv;
    bit to;
    restart(3, 0);
    for (int k = 1; k <= 3; k++) begin
      wait_valid(20, to);
      idx = cyc - base;
      n_checks++;
      if (to || idx !== 10 * k || wave !== 8'(exp_sample(3, k))) begin
        n_fail++;
        $display("FAIL rstdiv_pre phase=%0d: got cycle %0d value %0d, expected cycle %0d value %0d", k, idx, wave, 10 * k, exp_sample(3, k));
      end
    end
    repeat (4) step();
    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    step();
    n_checks++;
    if (wave !== 8'd0 || wave_valid !== 1'b0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rstdiv_reset: got wave=%0d valid=%b ps=%b, expected 0/0/0", wave, wave_valid, period_start);
    end
    rst = 1'b0;
    nv = 0;
    repeat (15) begin
      step();
      if (wave_valid === 1'b1) nv++;
    end
    n_checks++;
    if (nv !== 0) begin
      n_fail++;
      $display("FAIL rstdiv_no_valid: got %0d pulses, expected 0", nv);
    end
    en = 1'b1;
    base = cyc;
    for (int k = 1; k <= 3; k++) begin
      wait_valid(5, to);
      idx = cyc - base;
      n_checks++;
      if (to || idx !== k || wave !== 8'(k)) begin
        n_fail++;
        $display("FAIL rstdiv_restart phase=%0d: got cycle %0d value %0d, expected cycle %0d value %0d", k, idx, wave, k, k);
      end
    end
    en = 1'b0;
    mode = 2'd3;
    step();
    en = 1'b1;
    base = cyc;
    wait_valid(20, to);
    idx = cyc - base;
    n_checks++;
    if (to || idx !== 10 || wave !== 8'(exp_sample(3, 4))) begin
      n_fail++;
      $display("FAIL rstdiv_recip_after phase=4: got cycle %0d value %0d, expected cycle 10 value %0d", idx, wave, exp_sample(3, 4));
    end
  endtask

  task automatic test_en_pause();
    int idx, nv, got_s, got_w, p, pn, t, lat, e;
    bit to;
    restart(0, 0);
    repeat (249) begin
      wait_valid(5, to);
      if (to) break;
    end
    idx = cyc - base;
    n_checks++;
    if (to || idx !== 249 || wave !== 8'd249) begin
      n_fail++;
      $display("FAIL pause_prerun: got cycle %0d value %0d, expected cycle 249 value 249", idx, wave);
    end
    en = 1'b0;
    mode = 2'd3;
    nv = 0;
    repeat (20) begin
      step();
      if (wave_valid === 1'b1) nv++;
    end
    n_checks++;
    if (nv !== 0 || wave !== 8'd249) begin
      n_fail++;
      $display("FAIL pause_hold: got %0d pulses wave %0d, expected 0 pulses wave 249", nv, wave);
    end
    en = 1'b1;
    base = cyc;
    wait_valid(20, to);
    idx = cyc - base;
    n_checks++;
    if (to || idx !== 10 || wave !== 8'(exp_sample(3, 250))) begin
      n_fail++;
      $display("FAIL pause_resume phase=250: got cycle %0d value %0d, expected cycle 10 value %0d", idx, wave, exp_sample(3, 250));
    end
    repeat (3) step();
    en = 1'b0;
    nv = 0;
    got_s = -1;
    got_w = -1;
    repeat (20) begin
      step();
      if (wave_valid === 1'b1) begin
        nv++;
        got_s = cyc - base;
        got_w = int'(wave);
      end
    end
    n_checks++;
    if (nv !== 1 || got_s !== 20 || got_w !== exp_sample(3, 251)) begin
      n_fail++;
      $display("FAIL pause_inflight: got %0d pulses at cycle %0d value %0d, expected 1 at cycle 20 value %0d", nv, got_s, got_w, exp_sample(3, 251));
    end
    en = 1'b1;
    base = cyc;
    p = 251;
    t = 0;
    for (int k = 0; k < 7; k++) begin
      pn = (p + 1) % 256;
      lat = exp_lat(3, pn);
      e = exp_sample(3, pn);
      wait_valid(20, to);
      idx = cyc - base;
      n_checks++;
      if (to || idx !== t + lat || wave !== 8'(e) || period_start !== (pn == 0)) begin
        n_fail++;
        $display("FAIL pause_after phase=%0d: got cycle %0d value %0d ps %b, expected cycle %0d value %0d ps %b", pn, idx, wave, period_start, t + lat, e, pn == 0);
        if (to) break;
      end
      t = t + max2(1, lat);
      p = pn;
    end
  endtask

  initial begin
    test_reset();
    test_waveforms();
    test_mode_defer();
    test_rst_mid_div();
    test_en_pause();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
